// File: rtl/mic1_out_uart_tx.sv
// UART 8N1 transmitter that reports a 32-bit word as 8 uppercase hex digits plus CR LF.
// Optional change filter drops a word equal to the last one sent.
module mic1_out_uart_tx #(
  parameter int CLK_DIV     = 52,
  parameter bit CHANGE_ONLY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        ser_tx,
  output logic        busy
);

  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    idx_q, idx_d;
  logic [31:0]   shift_q, shift_d;
  logic [31:0]   last_q, last_d;
  logic          have_last_q, have_last_d;
  logic          ser_tx_q, ser_tx_d;

  logic [3:0] nib;
  logic [7:0] hex_char;
  logic [7:0] char_cur;
  logic [2:0] bit_nx;
  logic       baud_wrap;
  logic       drop;

  always_comb begin
    nib       = shift_q[31:28];
    hex_char  = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    char_cur  = (idx_q == 4'd8) ? 8'h0D : (idx_q == 4'd9) ? 8'h0A : hex_char;
    bit_nx    = bit_q + 3'd1;
    baud_wrap = (baud_q == BAUD_LAST);
    drop      = CHANGE_ONLY && have_last_q && (in_word == last_q);

    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    last_d      = last_q;
    have_last_d = have_last_q;
    ser_tx_d    = ser_tx_q;

    // ser_tx_d always reflects the state being entered, so the line is one flop deep
    unique case (state_q)
      S_IDLE: begin
        ser_tx_d = 1'b1;
        if (in_valid && !drop) begin
          shift_d     = in_word;
          last_d      = in_word;
          have_last_d = 1'b1;
          idx_d       = 4'd0;
          bit_d       = 3'd0;
          baud_d      = '0;
          state_d     = S_START;
          ser_tx_d    = 1'b0;
        end
      end
      S_START: begin
        baud_d = baud_q + BW'(1);
        if (baud_wrap) begin
          baud_d   = '0;
          bit_d    = 3'd0;
          state_d  = S_DATA;
          ser_tx_d = char_cur[0];
        end
      end
      S_DATA: begin
        baud_d = baud_q + BW'(1);
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d  = S_STOP;
            ser_tx_d = 1'b1;
          end else begin
            bit_d    = bit_nx;
            ser_tx_d = char_cur[bit_nx];
          end
        end
      end
      S_STOP: begin
        baud_d = baud_q + BW'(1);
        if (baud_wrap) begin
          baud_d = '0;
          if (idx_q == 4'd9) begin
            state_d  = S_IDLE;
            ser_tx_d = 1'b1;
          end else begin
            idx_d    = idx_q + 4'd1;
            shift_d  = {shift_q[27:0], 4'h0};
            state_d  = S_START;
            ser_tx_d = 1'b0;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        ser_tx_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= 3'd0;
      idx_q       <= 4'd0;
      shift_q     <= 32'h0;
      last_q      <= 32'h0;
      have_last_q <= 1'b0;
      ser_tx_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
      ser_tx_q    <= ser_tx_d;
    end
  end

  assign ser_tx   = ser_tx_q;
  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mic1_out_uart_tx.sv
// Directed bench for mic1_out_uart_tx: three instances (CLK_DIV 4/2/52) share clock and reset;
// a bit-level receiver decodes the line and checks framing, timing and handshake.
module tb_mic1_out_uart_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] iw4, iw2, iw52;
  logic        iv4, iv2, iv52;
  logic        rdy4, rdy2, rdy52;
  logic        tx4, tx2, tx52;
  logic        busy4, busy2, busy52;

  mic1_out_uart_tx #(.CLK_DIV(4), .CHANGE_ONLY(1'b1)) u4 (
    .clk(clk), .reset(rst), .in_word(iw4), .in_valid(iv4),
    .in_ready(rdy4), .ser_tx(tx4), .busy(busy4));
  mic1_out_uart_tx #(.CLK_DIV(2), .CHANGE_ONLY(1'b0)) u2 (
    .clk(clk), .reset(rst), .in_word(iw2), .in_valid(iv2),
    .in_ready(rdy2), .ser_tx(tx2), .busy(busy2));
  mic1_out_uart_tx #(.CLK_DIV(52), .CHANGE_ONLY(1'b1)) u52 (
    .clk(clk), .reset(rst), .in_word(iw52), .in_valid(iv52),
    .in_ready(rdy52), .ser_tx(tx52), .busy(busy52));

  int   sel;
  logic ser_mux, rdy_mux;
  always_comb begin
    ser_mux = tx4;
    rdy_mux = rdy4;
    if (sel == 1) begin
      ser_mux = tx2;
      rdy_mux = rdy2;
    end else if (sel == 2) begin
      ser_mux = tx52;
      rdy_mux = rdy52;
    end
  end

  int errors = 0;
  int checks = 0;

  logic [79:0] rx_data;
  int          rx_low;
  bit          rx_bad;
  int          high_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input int s, input logic [31:0] w);
    if (s == 0) begin iw4 = w; iv4 = 1'b1; end
    else if (s == 1) begin iw2 = w; iv2 = 1'b1; end
    else begin iw52 = w; iv52 = 1'b1; end
    tick();
    iv4 = 1'b0;
    iv2 = 1'b0;
    iv52 = 1'b0;
  endtask

  // Samples every cycle of a 10-character frame starting at the current (start-bit) cycle.
  task automatic recv(input int div, output logic [79:0] data, output int rdy_low, output bit bad);
    logic [7:0] ch;
    logic       v0;
    data    = '0;
    rdy_low = 0;
    bad     = 1'b0;
    for (int c = 0; c < 10; c++) begin
      ch = 8'h00;
      for (int fb = 0; fb < 10; fb++) begin
        v0 = 1'bx;
        for (int k = 0; k < div; k++) begin
          if (k == 0) v0 = ser_mux;
          else if (ser_mux !== v0) bad = 1'b1;
          if (rdy_mux === 1'b0) rdy_low++;
          tick();
        end
        if (fb == 0 && v0 !== 1'b0) bad = 1'b1;
        if (fb == 9 && v0 !== 1'b1) bad = 1'b1;
        if (fb >= 1 && fb <= 8) ch[fb-1] = v0;
      end
      data = {data[71:0], ch};
    end
  endtask

  initial begin
    sel = 0;
    iw4 = 32'h0; iw2 = 32'h0; iw52 = 32'h0;
    iv4 = 1'b0; iv2 = 1'b0; iv52 = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("reset_tx4", 80'(tx4), 80'(1'b1));
    chk("reset_rdy4", 80'(rdy4), 80'(1'b1));
    chk("reset_busy4", 80'(busy4), 80'(1'b0));
    chk("reset_tx52", 80'(tx52), 80'(1'b1));
    rst = 1'b0;
    tick();
    tick();
    chk("idle_tx4", 80'(tx4), 80'(1'b1));

    // Basic frame, CLK_DIV=4
    offer(0, 32'h00001F0A);
    chk("t1_start_bit", 80'(tx4), 80'(1'b0));
    chk("t1_busy", 80'(busy4), 80'(1'b1));
    recv(4, rx_data, rx_low, rx_bad);
    chk("t1_data", rx_data, {"00001F0A", 8'h0D, 8'h0A});
    chk("t1_framing", 80'(rx_bad), 80'(1'b0));
    chk("t1_ready_low", 80'(rx_low), 80'(400));
    chk("t1_ready_back", 80'(rdy4), 80'(1'b1));
    chk("t1_busy_fall", 80'(busy4), 80'(1'b0));

    // Change filter
    offer(0, 32'hDEADBEEF);
    recv(4, rx_data, rx_low, rx_bad);
    chk("t2_data", rx_data, {"DEADBEEF", 8'h0D, 8'h0A});
    chk("t2_framing", 80'(rx_bad), 80'(1'b0));
    tick();
    iw4 = 32'hDEADBEEF;
    iv4 = 1'b1;
    high_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx4 === 1'b1 && rdy4 === 1'b1) high_cnt++;
    end
    iv4 = 1'b0;
    chk("t2_repeat_dropped", 80'(high_cnt), 80'(20));
    offer(0, 32'hDEADBEF0);
    chk("t2_new_accepted", 80'(rdy4), 80'(1'b0));
    recv(4, rx_data, rx_low, rx_bad);
    chk("t2_data2", rx_data, {"DEADBEF0", 8'h0D, 8'h0A});

    // in_valid held high, alternating words changed while busy
    tick();
    iw4 = 32'h1;
    iv4 = 1'b1;
    tick();
    iw4 = 32'h2;
    chk("t3_start_a", 80'(tx4), 80'(1'b0));
    recv(4, rx_data, rx_low, rx_bad);
    chk("t3_data_a", rx_data, {"00000001", 8'h0D, 8'h0A});
    chk("t3_ready_low_a", 80'(rx_low), 80'(400));
    chk("t3_gap_a", 80'({tx4, rdy4}), 80'(2'b11));
    tick();
    chk("t3_start_b", 80'(tx4), 80'(1'b0));
    iw4 = 32'h1;
    recv(4, rx_data, rx_low, rx_bad);
    chk("t3_data_b", rx_data, {"00000002", 8'h0D, 8'h0A});
    chk("t3_gap_b", 80'({tx4, rdy4}), 80'(2'b11));
    tick();
    chk("t3_start_c", 80'(tx4), 80'(1'b0));
    iv4 = 1'b0;
    recv(4, rx_data, rx_low, rx_bad);
    chk("t3_data_c", rx_data, {"00000001", 8'h0D, 8'h0A});
    chk("t3_framing", 80'(rx_bad), 80'(1'b0));
    tick();
    chk("t3_no_extra", 80'({tx4, rdy4}), 80'(2'b11));

    // Asynchronous reset mid-frame
    offer(0, 32'h12345678);
    repeat (150) tick();
    chk("t4_pre_reset_tx", 80'(tx4), 80'(1'b0));
    rst = 1'b1;
    #1;
    chk("t4_reset_tx_now", 80'(tx4), 80'(1'b1));
    tick();
    rst = 1'b0;
    tick();
    chk("t4_ready_after", 80'(rdy4), 80'(1'b1));
    chk("t4_busy_after", 80'(busy4), 80'(1'b0));
    offer(0, 32'h12345678);
    chk("t4_resend_accepted", 80'(rdy4), 80'(1'b0));
    recv(4, rx_data, rx_low, rx_bad);
    chk("t4_data", rx_data, {"12345678", 8'h0D, 8'h0A});

    // CHANGE_ONLY=0, CLK_DIV=2
    sel = 1;
    offer(1, 32'hFFFFFFFF);
    recv(2, rx_data, rx_low, rx_bad);
    chk("t5_data_a", rx_data, {"FFFFFFFF", 8'h0D, 8'h0A});
    chk("t5_len_a", 80'(rx_low), 80'(200));
    offer(1, 32'hFFFFFFFF);
    chk("t5_start_b", 80'(tx2), 80'(1'b0));
    recv(2, rx_data, rx_low, rx_bad);
    chk("t5_data_b", rx_data, {"FFFFFFFF", 8'h0D, 8'h0A});
    chk("t5_len_b", 80'(rx_low), 80'(200));
    chk("t5_framing", 80'(rx_bad), 80'(1'b0));

    // CLK_DIV=52
    sel = 2;
    offer(2, 32'h0);
    high_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (i < 52 && tx52 === 1'b0) high_cnt++;
      if (i >= 52 && i < 60 && tx52 !== 1'b0) high_cnt = -1000;
      tick();
    end
    // '0' = 0x30 has data bit 0 low, so the line stays low straight after the start bit
    chk("t6_start_width", 80'(high_cnt), 80'(52));
    repeat (52 * 100 - 60) tick();
    chk("t6_frame_end", 80'({rdy52, tx52}), 80'(2'b11));
    offer(2, 32'hA5);
    recv(52, rx_data, rx_low, rx_bad);
    chk("t6_data", rx_data, {"000000A5", 8'h0D, 8'h0A});
    chk("t6_len", 80'(rx_low), 80'(5200));
    chk("t6_framing", 80'(rx_bad), 80'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mic1_out_uart_tx.md
Name: mic1_out_uart_tx

Overview:
UART transmitter that reports the MIC-1 SoC's 32-bit `out` word over the board TX pin. It replaces the constant-high TX drive in the iCEBreaker top level. Each accepted word is sent as 8 uppercase ASCII hex digits, MSB nibble first, followed by CR LF. Framing is 8N1. An optional change filter suppresses repeats so a polling top level does not flood the host.

Parameters:
CLK_DIV, 52, clock cycles per UART bit (6 MHz / 115200 ≈ 52); legal range 2..65535
CHANGE_ONLY, 1, when 1 a word equal to the last transmitted word is accepted and silently dropped

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-high
in_word  input  32  word to report (SoC `out`)
in_valid  input  1  in_word is offered this cycle
in_ready  output  1  block can accept a word this cycle
ser_tx  output  1  UART line, idle high
busy  output  1  a frame is in progress

Behaviour:
- Reset values: ser_tx=1, in_ready=1, busy=0, state=IDLE, have_last=0, last_word=0, all counters 0.
- Reset is asynchronous. Asserting it mid-frame forces ser_tx=1 immediately and discards the current word. No partial-character recovery is attempted.
- Acceptance: a word is accepted on a rising clk edge where in_valid && in_ready. in_ready is high only in IDLE. in_valid while in_ready=0 is ignored; no queueing.
- Change filter (CHANGE_ONLY=1): if have_last && in_word==last_word at acceptance, the block stays in IDLE. Nothing is sent and in_ready stays 1.
- Otherwise on acceptance:
  - latch in_word into shift_word and last_word; set have_last=1.
  - char index=0, state=START.
  - in_ready=0 and busy=1 from the next cycle.
- Character sequence, index 0..9:
  - index 0..7: hex digit of nibble [31-4i:28-4i]. Values 0..9 map to 0x30..0x39; values A..F map to 0x41..0x46.
  - index 8: 0x0D.
  - index 9: 0x0A.
- FSM states and transitions:
  - IDLE: ser_tx=1.
  - START: ser_tx=0 for CLK_DIV cycles, then DATA with bit=0.
  - DATA: ser_tx=char[bit] (LSB first) for CLK_DIV cycles per bit. After bit 7 go to STOP.
  - STOP: ser_tx=1 for CLK_DIV cycles. Then, if index<9: index+1 and go to START. If index==9: go to IDLE.
- Registered output: ser_tx is driven from a flop, so no glitches.
- Timing:
  - Start bit of character 0 begins the cycle after acceptance.
  - Characters are back-to-back with no inter-character gap.
  - Frame length is exactly 100*CLK_DIV cycles.
  - in_ready returns to 1 in the first cycle after the last stop-bit cycle; busy falls in the same cycle.
  - A word accepted in that cycle has its start bit one cycle later, so there is a minimum of 1 idle cycle between frames.
- Counters:
  - baud counter is ceil(log2(CLK_DIV)) bits and counts 0..CLK_DIV-1, wrapping at CLK_DIV-1 to advance bit/state.
  - bit counter is 3 bits; char index is 4 bits.
  - No counter runs in IDLE; the baud counter is cleared on entry to START.
- in_word changing while busy has no effect on the frame in flight.

Test Plan:
- CLK_DIV=4: reset, then in_word=0x00001F0A with in_valid for 1 cycle → ser_tx decodes to "00001F0A\r\n" (30 30 30 30 31 46 30 41 0D 0A). The start bit falls 1 cycle after acceptance, every bit lasts 4 cycles, and in_ready is low for exactly 400 cycles.
- CHANGE_ONLY=1: send 0xDEADBEEF, wait for idle, offer 0xDEADBEEF again → ser_tx stays 1 and in_ready stays 1. Then offer 0xDEADBEF0 → "DEADBEF0\r\n" is sent.
- in_valid held high continuously with alternating words 0x1/0x2, CLK_DIV=4 → consecutive frames are separated by exactly 1 idle-high cycle. in_valid during busy is ignored, and no word is lost or duplicated beyond those accepted.
- Assert reset at cycle 150 of a frame → ser_tx=1 in the same cycle (before any clk edge), in_ready=1 and busy=0 after release. The next offered word equal to the aborted one is sent, because have_last was cleared.
- CHANGE_ONLY=0, CLK_DIV=2: offer 0xFFFFFFFF twice → two identical "FFFFFFFF\r\n" frames of 200 cycles each.
- CLK_DIV=52: offer 0x0 → a measured start-bit width of 52 cycles, and a frame length of 5200 cycles.
